// File: rtl/mem_arbiter.sv
// mem_arbiter
// -----------
// Two-port (instruction / data) arbiter in front of a single shared memory
// request channel. One transaction is outstanding at a time. The winning
// port's request is latched into the m_* output registers and held until
// the memory acknowledges or the BUSY wait limit expires. Completion is
// reported to the owning port as a one-cycle done pulse. On a timeout,
// err pulses with done and rdata is cleared.
//
// Parameters
//   XLEN    : address and data width
//   TIMEOUT : maximum number of BUSY cycles to wait for m_ack (2..255)
//
// Configuration macro
//   MEM_ARBITER_RR_EN : defined   -> round-robin tie-break (I wins first tie)
//                       undefined -> fixed priority, D wins every tie
//
// Ports
//   clk, rst_n                           clock, synchronous active-low reset
//   i_req, i_adr                         instruction read request
//   i_rdata, i_done, i_err               instruction completion
//   d_req, d_we, d_adr, d_wdata,
//   d_strobe                             data request
//   d_rdata, d_done, d_err               data completion
//   m_r_v, m_w_v, m_adr, m_data,
//   m_strobe                             shared memory request (registered)
//   m_resp, m_ack                        memory read data and completion
module mem_arbiter #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_req,
  input  logic [XLEN-1:0] i_adr,
  output logic [XLEN-1:0] i_rdata,
  output logic            i_done,
  output logic            i_err,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [XLEN-1:0] d_adr,
  input  logic [XLEN-1:0] d_wdata,
  input  logic [3:0]      d_strobe,
  output logic [XLEN-1:0] d_rdata,
  output logic            d_done,
  output logic            d_err,
  output logic            m_r_v,
  output logic            m_w_v,
  output logic [XLEN-1:0] m_adr,
  output logic [XLEN-1:0] m_data,
  output logic [3:0]      m_strobe,
  input  logic [XLEN-1:0] m_resp,
  input  logic            m_ack
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

  localparam logic       OWNER_I  = 1'b0;
  localparam logic       OWNER_D  = 1'b1;
  // Last counter value before the wait limit; the counter is 0 in the
  // first BUSY cycle, so TIMEOUT BUSY cycles elapse before giving up.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              m_r_v_q, m_r_v_d;
  logic              m_w_v_q, m_w_v_d;
  logic [XLEN-1:0]   m_adr_q, m_adr_d;
  logic [XLEN-1:0]   m_data_q, m_data_d;
  logic [3:0]        m_strobe_q, m_strobe_d;
  logic [XLEN-1:0]   i_rdata_q, i_rdata_d;
  logic              i_done_q, i_done_d;
  logic              i_err_q, i_err_d;
  logic [XLEN-1:0]   d_rdata_q, d_rdata_d;
  logic              d_done_q, d_done_d;
  logic              d_err_q, d_err_d;

  logic              i_elig;
  logic              d_elig;
  logic              grant_d;
  logic              finish;
  logic [XLEN-1:0]   fin_data;

  // A port completing this cycle is still dropping its request, so it
  // must not be granted again on the stale req.
  assign i_elig = i_req & ~i_done_q;
  assign d_elig = d_req & ~d_done_q;

  // Completion happens on ack, or when the wait limit is reached; ack in
  // the limit cycle wins, so the data/err choice keys off m_ack alone.
  assign finish   = (state_q == BUSY) & (m_ack | (cnt_q == CNT_LAST));
  assign fin_data = m_ack ? m_resp : {XLEN{1'b0}};

`ifdef MEM_ARBITER_RR_EN
  logic last_d_q, last_d_d;

  // On a tie, the port that was not served most recently wins.
  assign grant_d = d_elig & (~i_elig | ~last_d_q);

  // Last-served port register; resets to D so I takes the first tie.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_d_q <= 1'b1;
    end else begin
      last_d_q <= last_d_d;
    end
  end
`else
  // Fixed priority: D wins whenever it is eligible.
  assign grant_d = d_elig;
`endif

  // Next-state, request latching and completion reporting.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    m_r_v_d    = m_r_v_q;
    m_w_v_d    = m_w_v_q;
    m_adr_d    = m_adr_q;
    m_data_d   = m_data_q;
    m_strobe_d = m_strobe_q;
    i_rdata_d  = i_rdata_q;
    i_done_d   = 1'b0;
    i_err_d    = 1'b0;
    d_rdata_d  = d_rdata_q;
    d_done_d   = 1'b0;
    d_err_d    = 1'b0;
`ifdef MEM_ARBITER_RR_EN
    last_d_d   = last_d_q;
`endif

    case (state_q)
      IDLE: begin
        if (i_elig | d_elig) begin
          state_d = BUSY;
          owner_d = grant_d;
          cnt_d   = 8'd0;
`ifdef MEM_ARBITER_RR_EN
          last_d_d = grant_d;
`endif
          if (grant_d) begin
            m_r_v_d    = ~d_we;
            m_w_v_d    = d_we;
            m_adr_d    = d_adr;
            m_data_d   = d_wdata;
            m_strobe_d = d_strobe;
          end else begin
            // Instruction fetches are always full-word reads.
            m_r_v_d    = 1'b1;
            m_w_v_d    = 1'b0;
            m_adr_d    = i_adr;
            m_data_d   = {XLEN{1'b0}};
            m_strobe_d = 4'hF;
          end
        end else begin
          state_d = IDLE;
        end
      end

      BUSY: begin
        if (finish) begin
          state_d    = IDLE;
          cnt_d      = 8'd0;
          m_r_v_d    = 1'b0;
          m_w_v_d    = 1'b0;
          m_adr_d    = {XLEN{1'b0}};
          m_data_d   = {XLEN{1'b0}};
          m_strobe_d = 4'h0;
          if (owner_q == OWNER_D) begin
            d_rdata_d = fin_data;
            d_done_d  = 1'b1;
            d_err_d   = ~m_ack;
          end else begin
            i_rdata_d = fin_data;
            i_done_d  = 1'b1;
            i_err_d   = ~m_ack;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      owner_q    <= OWNER_I;
      cnt_q      <= 8'd0;
      m_r_v_q    <= 1'b0;
      m_w_v_q    <= 1'b0;
      m_adr_q    <= {XLEN{1'b0}};
      m_data_q   <= {XLEN{1'b0}};
      m_strobe_q <= 4'h0;
      i_rdata_q  <= {XLEN{1'b0}};
      i_done_q   <= 1'b0;
      i_err_q    <= 1'b0;
      d_rdata_q  <= {XLEN{1'b0}};
      d_done_q   <= 1'b0;
      d_err_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      cnt_q      <= cnt_d;
      m_r_v_q    <= m_r_v_d;
      m_w_v_q    <= m_w_v_d;
      m_adr_q    <= m_adr_d;
      m_data_q   <= m_data_d;
      m_strobe_q <= m_strobe_d;
      i_rdata_q  <= i_rdata_d;
      i_done_q   <= i_done_d;
      i_err_q    <= i_err_d;
      d_rdata_q  <= d_rdata_d;
      d_done_q   <= d_done_d;
      d_err_q    <= d_err_d;
    end
  end

  assign m_r_v    = m_r_v_q;
  assign m_w_v    = m_w_v_q;
  assign m_adr    = m_adr_q;
  assign m_data   = m_data_q;
  assign m_strobe = m_strobe_q;
  assign i_rdata  = i_rdata_q;
  assign i_done   = i_done_q;
  assign i_err    = i_err_q;
  assign d_rdata  = d_rdata_q;
  assign d_done   = d_done_q;
  assign d_err    = d_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// --------------
// Self-checking bench for mem_arbiter. A transaction-level reference model
// (one outstanding memory request, its wait age, and the per-port result
// registers) is advanced on every rising edge and compared against every
// DUT output on every falling edge. Directed scenarios pin the model with
// hand-computed literals; a randomized phase with varying ack density,
// occasional resets and requester drops follows.
module tb_mem_arbiter;

  localparam int XLEN    = 32;
  localparam int TIMEOUT = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            i_req = 1'b0;
  logic [XLEN-1:0] i_adr = '0;
  logic [XLEN-1:0] i_rdata;
  logic            i_done;
  logic            i_err;
  logic            d_req = 1'b0;
  logic            d_we = 1'b0;
  logic [XLEN-1:0] d_adr = '0;
  logic [XLEN-1:0] d_wdata = '0;
  logic [3:0]      d_strobe = 4'h0;
  logic [XLEN-1:0] d_rdata;
  logic            d_done;
  logic            d_err;
  logic            m_r_v;
  logic            m_w_v;
  logic [XLEN-1:0] m_adr;
  logic [XLEN-1:0] m_data;
  logic [3:0]      m_strobe;
  logic [XLEN-1:0] m_resp = '0;
  logic            m_ack = 1'b0;

  always #5 clk = ~clk;

  mem_arbiter #(.XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_adr(i_adr),
    .i_rdata(i_rdata), .i_done(i_done), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_adr(d_adr), .d_wdata(d_wdata), .d_strobe(d_strobe),
    .d_rdata(d_rdata), .d_done(d_done), .d_err(d_err),
    .m_r_v(m_r_v), .m_w_v(m_w_v), .m_adr(m_adr), .m_data(m_data), .m_strobe(m_strobe),
    .m_resp(m_resp), .m_ack(m_ack)
  );

  int vectors = 0;
  int errors  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Outstanding request (if any), how many BUSY cycles it has waited,
  // which port was served last, and what each port should be showing.
  logic            mdl_busy = 1'b0;
  logic            mdl_own_d = 1'b0;
  logic            mdl_we = 1'b0;
  logic [XLEN-1:0] mdl_adr = '0;
  logic [XLEN-1:0] mdl_wdata = '0;
  logic [3:0]      mdl_strb = 4'h0;
  int              mdl_waited = 0;
  logic            mdl_last_d = 1'b1;
  logic [XLEN-1:0] e_i_rdata = '0;
  logic            e_i_done = 1'b0;
  logic            e_i_err = 1'b0;
  logic [XLEN-1:0] e_d_rdata = '0;
  logic            e_d_done = 1'b0;
  logic            e_d_err = 1'b0;

  task automatic model_update();
    logic i_el, d_el, take_d, fin, ferr;
    logic [XLEN-1:0] fdata;
    if (!rst_n) begin
      mdl_busy = 1'b0; mdl_own_d = 1'b0; mdl_waited = 0; mdl_last_d = 1'b1;
      e_i_rdata = '0; e_i_done = 1'b0; e_i_err = 1'b0;
      e_d_rdata = '0; e_d_done = 1'b0; e_d_err = 1'b0;
    end else begin
      i_el = i_req && !e_i_done;
      d_el = d_req && !e_d_done;
      e_i_done = 1'b0; e_i_err = 1'b0; e_d_done = 1'b0; e_d_err = 1'b0;
      if (mdl_busy) begin
        mdl_waited = mdl_waited + 1;
        fin = 1'b0; ferr = 1'b0; fdata = '0;
        if (m_ack) begin
          fin = 1'b1; fdata = m_resp;
        end else if (mdl_waited == TIMEOUT) begin
          fin = 1'b1; ferr = 1'b1;
        end
        if (fin) begin
          mdl_busy = 1'b0;
          if (mdl_own_d) begin e_d_done = 1'b1; e_d_err = ferr; e_d_rdata = fdata; end
          else begin e_i_done = 1'b1; e_i_err = ferr; e_i_rdata = fdata; end
        end
      end else if (i_el || d_el) begin
`ifdef MEM_ARBITER_RR_EN
        take_d = d_el && (!i_el || !mdl_last_d);
`else
        take_d = d_el;
`endif
        mdl_busy = 1'b1; mdl_waited = 0; mdl_own_d = take_d; mdl_last_d = take_d;
        if (take_d) begin
          mdl_we = d_we; mdl_adr = d_adr; mdl_wdata = d_wdata; mdl_strb = d_strobe;
        end else begin
          mdl_we = 1'b0; mdl_adr = i_adr; mdl_wdata = '0; mdl_strb = 4'hF;
        end
      end
    end
  endtask

  // Model advances on the rising edge; DUT outputs are compared mid-cycle.
  initial begin
    forever begin
      @(posedge clk);
      model_update();
      @(negedge clk);
      chk("m_r_v",    32'(m_r_v),    32'(mdl_busy && !mdl_we));
      chk("m_w_v",    32'(m_w_v),    32'(mdl_busy && mdl_we));
      chk("m_adr",    m_adr,         mdl_busy ? mdl_adr : 32'h0);
      chk("m_data",   m_data,        mdl_busy ? mdl_wdata : 32'h0);
      chk("m_strobe", 32'(m_strobe), mdl_busy ? 32'(mdl_strb) : 32'h0);
      chk("i_done",   32'(i_done),   32'(e_i_done));
      chk("i_err",    32'(i_err),    32'(e_i_err));
      chk("i_rdata",  i_rdata,       e_i_rdata);
      chk("d_done",   32'(d_done),   32'(e_d_done));
      chk("d_err",    32'(d_err),    32'(e_d_err));
      chk("d_rdata",  d_rdata,       e_d_rdata);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] arb_exp [4];
  logic [1:0] got;
  int         p;

  initial begin
`ifdef MEM_ARBITER_RR_EN
    arb_exp[0] = 2'd0; arb_exp[1] = 2'd1; arb_exp[2] = 2'd0; arb_exp[3] = 2'd1;
`else
    arb_exp[0] = 2'd1; arb_exp[1] = 2'd1; arb_exp[2] = 2'd1; arb_exp[3] = 2'd1;
`endif

    // Reset state
    tick(); tick();
    chk("rst_m_r_v", 32'(m_r_v), 32'h0);
    chk("rst_m_w_v", 32'(m_w_v), 32'h0);
    chk("rst_m_adr", m_adr, 32'h0);
    chk("rst_m_strobe", 32'(m_strobe), 32'h0);
    chk("rst_i_done", 32'(i_done), 32'h0);
    chk("rst_d_rdata", d_rdata, 32'h0);
    rst_n = 1'b1;
    tick();

    // Instruction read, ack in first BUSY cycle
    i_req = 1'b1; i_adr = 32'h40; m_ack = 1'b1; m_resp = 32'hDEADBEEF;
    tick();
    chk("s1_m_r_v", 32'(m_r_v), 32'h1);
    chk("s1_m_adr", m_adr, 32'h40);
    chk("s1_m_strobe", 32'(m_strobe), 32'hF);
    tick();
    chk("s1_i_done", 32'(i_done), 32'h1);
    chk("s1_i_rdata", i_rdata, 32'hDEADBEEF);
    chk("s1_mdl_rdata", e_i_rdata, 32'hDEADBEEF);
    chk("s1_m_r_v_off", 32'(m_r_v), 32'h0);
    i_req = 1'b0; m_ack = 1'b0;
    tick();
    chk("s1_i_done_pulse", 32'(i_done), 32'h0);

    // Data write, ack in third BUSY cycle
    d_req = 1'b1; d_we = 1'b1; d_adr = 32'h100; d_wdata = 32'h11223344; d_strobe = 4'b0011;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("s2_m_w_v", 32'(m_w_v), 32'h1);
      chk("s2_m_r_v", 32'(m_r_v), 32'h0);
      chk("s2_m_adr", m_adr, 32'h100);
      chk("s2_m_data", m_data, 32'h11223344);
      chk("s2_m_strobe", 32'(m_strobe), 32'h3);
    end
    m_ack = 1'b1; m_resp = 32'h55AA00FF;
    tick();
    chk("s2_d_done", 32'(d_done), 32'h1);
    chk("s2_d_err", 32'(d_err), 32'h0);
    chk("s2_d_rdata", d_rdata, 32'h55AA00FF);
    chk("s2_m_w_v_off", 32'(m_w_v), 32'h0);
    d_req = 1'b0; m_ack = 1'b0;
    tick();
    chk("s2_d_done_pulse", 32'(d_done), 32'h0);

    // Both ports re-asserted together for four rounds
    for (int r = 0; r < 4; r++) begin
      i_req = 1'b1; i_adr = 32'h1000 + 32'(r);
      d_req = 1'b1; d_we = 1'b0; d_adr = 32'h2000 + 32'(r);
      m_ack = 1'b1; m_resp = 32'hA0 + 32'(r);
      got = 2'd3;
      for (int k = 0; k < 10 && got == 2'd3; k++) begin
        tick();
        if (i_done) got = 2'd0;
        else if (d_done) got = 2'd1;
      end
      chk("s3_winner", 32'(got), 32'(arb_exp[r]));
      i_req = 1'b0; d_req = 1'b0; m_ack = 1'b0;
      tick();
    end

    // Timeout: no ack
    i_req = 1'b1; i_adr = 32'h80; m_ack = 1'b0;
    for (int k = 0; k < TIMEOUT; k++) begin
      tick();
      chk("s4_m_r_v", 32'(m_r_v), 32'h1);
      chk("s4_i_done_early", 32'(i_done), 32'h0);
    end
    tick();
    chk("s4_i_done", 32'(i_done), 32'h1);
    chk("s4_i_err", 32'(i_err), 32'h1);
    chk("s4_i_rdata", i_rdata, 32'h0);
    chk("s4_m_r_v_off", 32'(m_r_v), 32'h0);
    i_req = 1'b0;
    d_req = 1'b1; d_we = 1'b0; d_adr = 32'h200; m_ack = 1'b1; m_resp = 32'h0BADF00D;
    tick();
    chk("s4_next_adr", m_adr, 32'h200);
    tick();
    chk("s4_next_done", 32'(d_done), 32'h1);
    chk("s4_next_err", 32'(d_err), 32'h0);
    chk("s4_next_rdata", d_rdata, 32'h0BADF00D);
    d_req = 1'b0; m_ack = 1'b0;
    tick();

    // Reset in the second BUSY cycle, late ack afterwards
    d_req = 1'b1; d_we = 1'b1; d_adr = 32'h400; d_wdata = 32'hA5A5A5A5; d_strobe = 4'hC;
    tick();
    chk("s5_busy1", 32'(m_w_v), 32'h1);
    tick();
    rst_n = 1'b0; d_req = 1'b0;
    tick();
    rst_n = 1'b1; m_ack = 1'b1; m_resp = 32'h77777777;
    chk("s5_m_w_v", 32'(m_w_v), 32'h0);
    chk("s5_m_adr", m_adr, 32'h0);
    chk("s5_d_done", 32'(d_done), 32'h0);
    chk("s5_d_rdata", d_rdata, 32'h0);
    tick();
    chk("s5_late_done", 32'(d_done), 32'h0);
    chk("s5_idle_r", 32'(m_r_v), 32'h0);
    chk("s5_idle_w", 32'(m_w_v), 32'h0);
    m_ack = 1'b0;
    tick();

    // Request dropped mid-BUSY still completes once
    d_req = 1'b1; d_we = 1'b0; d_adr = 32'h300;
    tick();
    chk("s6_busy", 32'(m_r_v), 32'h1);
    d_req = 1'b0;
    tick();
    m_ack = 1'b1; m_resp = 32'h13579BDF;
    tick();
    chk("s6_d_done", 32'(d_done), 32'h1);
    chk("s6_d_rdata", d_rdata, 32'h13579BDF);
    m_ack = 1'b0;
    tick();
    chk("s6_d_done_once", 32'(d_done), 32'h0);
    chk("s6_no_new", 32'(m_r_v | m_w_v), 32'h0);
    tick();

    // Randomized traffic with falling ack density and occasional resets
    for (int c = 0; c < 3000; c++) begin
      p = (c < 1000) ? 50 : ((c < 2000) ? 12 : 3);
      if (i_req && i_done) i_req = 1'b0;
      else if (!i_req) begin
        if ($urandom_range(3) == 0) begin i_req = 1'b1; i_adr = $urandom; end
      end else if ($urandom_range(63) == 0) i_req = 1'b0;
      if (d_req && d_done) d_req = 1'b0;
      else if (!d_req) begin
        if ($urandom_range(3) == 0) begin
          d_req = 1'b1; d_we = 1'($urandom_range(1)); d_adr = $urandom;
          d_wdata = $urandom; d_strobe = 4'($urandom_range(15));
        end
      end else if ($urandom_range(63) == 0) d_req = 1'b0;
      m_ack  = ($urandom_range(99) < p);
      m_resp = $urandom;
      rst_n  = ($urandom_range(499) != 0);
      if (!rst_n) begin i_req = 1'b0; d_req = 1'b0; end
      tick();
    end
    rst_n = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
